// File: rtl/tetris_vga_render.sv
// 640x480@60 Hz VGA renderer for the 10x20 Tetris playfield.
// Takes a tear-free snapshot of the grid once per frame, during vertical blanking.
module tetris_vga_render #(
    parameter int PF_X0 = 240,
    parameter int PF_Y0 = 80
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [199:0] grid_state,
    input  logic         game_over,
    output logic         vga_hs,
    output logic         vga_vs,
    output logic [3:0]   vga_r,
    output logic [3:0]   vga_g,
    output logic [3:0]   vga_b,
    output logic         frame_start
);

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd752;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd492;
    localparam logic [9:0] V_LAST       = 10'd524;

    localparam logic [9:0] PF_LEFT   = 10'(PF_X0);
    localparam logic [9:0] PF_RIGHT  = 10'(PF_X0 + 160);
    localparam logic [9:0] PF_TOP    = 10'(PF_Y0);
    localparam logic [9:0] PF_BOTTOM = 10'(PF_Y0 + 320);
    localparam logic [9:0] BD_LEFT   = 10'(PF_X0 - 8);
    localparam logic [9:0] BD_RIGHT  = 10'(PF_X0 + 168);
    localparam logic [9:0] BD_TOP    = 10'(PF_Y0 - 8);
    localparam logic [9:0] BD_BOTTOM = 10'(PF_Y0 + 328);

    localparam logic [11:0] RGB_BLACK = 12'h000;
    localparam logic [11:0] RGB_GREY  = 12'h222;
    localparam logic [11:0] RGB_WHITE = 12'hFFF;
    localparam logic [11:0] RGB_CYAN  = 12'h0FF;
    localparam logic [11:0] RGB_RED   = 12'hF00;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic [11:0] rgb;
    } vga_out_t;

    localparam vga_out_t OUT_IDLE = '{hs: 1'b1, vs: 1'b1, rgb: RGB_BLACK};

    logic         pix_en;
    logic [9:0]   h;
    logic [9:0]   v;
    logic [199:0] snap;
    logic         snap_go;
    vga_out_t     pix_next;
    vga_out_t     pix_q;

    logic         visible;
    logic         in_pf;
    logic         in_border;
    logic         snapshot;
    logic [7:0]   dx;
    logic [8:0]   dy;
    logic [3:0]   cell_c;
    logic [4:0]   cell_r;
    logic [7:0]   cell_idx;

    assign visible   = (h < H_VISIBLE) && (v < V_VISIBLE);
    assign in_pf     = (h >= PF_LEFT) && (h < PF_RIGHT) && (v >= PF_TOP) && (v < PF_BOTTOM);
    assign in_border = (h >= BD_LEFT) && (h < BD_RIGHT) && (v >= BD_TOP) && (v < BD_BOTTOM);
    assign snapshot  = pix_en && (h == 10'd0) && (v == V_VISIBLE);

    // Offsets are only meaningful inside the playfield, where they fit these widths.
    assign dx       = 8'(h - PF_LEFT);
    assign dy       = 9'(v - PF_TOP);
    assign cell_c   = dx[7:4];
    assign cell_r   = dy[8:4];
    assign cell_idx = {cell_r, 3'b000} + {2'b00, cell_r, 1'b0} + {4'b0000, cell_c};

    always_comb begin
        // NOTE: defaults first so every path assigns every field and no latch is inferred.
        pix_next     = OUT_IDLE;
        pix_next.hs  = !((h >= H_SYNC_START) && (h < H_SYNC_END));
        pix_next.vs  = !((v >= V_SYNC_START) && (v < V_SYNC_END));
        if (!visible) begin
            pix_next.rgb = RGB_BLACK;
        end else if (in_pf) begin
            if ((dx[3:0] == 4'hF) || (dy[3:0] == 4'hF)) begin
                pix_next.rgb = RGB_GREY;
            end else if (snap[cell_idx]) begin
                pix_next.rgb = snap_go ? RGB_RED : RGB_CYAN;
            end else begin
                pix_next.rgb = RGB_GREY;
            end
        end else if (in_border) begin
            pix_next.rgb = RGB_WHITE;
        end
    end

    // NOTE: non-blocking assignments so every register samples the pre-edge state.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pix_en      <= 1'b0;
            h           <= '0;
            v           <= '0;
            // NOTE: snap is a plain register, not a memory, so it takes the reset too.
            snap        <= '0;
            snap_go     <= 1'b0;
            frame_start <= 1'b0;
            pix_q       <= OUT_IDLE;
        end else begin
            pix_en      <= !pix_en;
            frame_start <= snapshot;
            if (pix_en) begin
                pix_q <= pix_next;
                if (h == H_LAST) begin
                    h <= '0;
                    v <= (v == V_LAST) ? 10'd0 : v + 10'd1;
                end else begin
                    h <= h + 10'd1;
                end
                if (snapshot) begin
                    snap    <= grid_state;
                    snap_go <= game_over;
                end
            end
        end
    end

    assign vga_hs = pix_q.hs;
    assign vga_vs = pix_q.vs;
    assign vga_r  = pix_q.rgb[11:8];
    assign vga_g  = pix_q.rgb[7:4];
    assign vga_b  = pix_q.rgb[3:0];

endmodule

// File: tb/tb_tetris_vga_render.sv
// Self-checking bench for tetris_vga_render: every clk is compared against a
// coordinate/colour model derived from the strobe count since reset release.
module tb_tetris_vga_render;

    localparam int PF_X0     = 240;
    localparam int PF_Y0     = 80;
    localparam int GOTO_MAX  = 900000;
    localparam int ABORT_AT  = 200;

    logic         clk = 1'b0;
    logic         reset_n;
    logic [199:0] grid_state;
    logic         game_over;
    logic         vga_hs;
    logic         vga_vs;
    logic [3:0]   vga_r;
    logic [3:0]   vga_g;
    logic [3:0]   vga_b;
    logic         frame_start;

    tetris_vga_render #(.PF_X0(PF_X0), .PF_Y0(PF_Y0)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .grid_state  (grid_state),
        .game_over   (game_over),
        .vga_hs      (vga_hs),
        .vga_vs      (vga_vs),
        .vga_r       (vga_r),
        .vga_g       (vga_g),
        .vga_b       (vga_b),
        .frame_start (frame_start)
    );

    always #10 clk = ~clk;

    int compared = 0;
    int mism     = 0;

    // Model state: clks since release, last strobed coordinate, model snapshot.
    int           since = 0;
    int           cur_h = -1;
    int           cur_v = -1;
    logic [199:0] snap_m = '0;
    logic         go_m = 1'b0;
    logic [13:0]  exp_out = 14'h3000;
    logic         exp_fs = 1'b0;

    int   fs_count = 0;
    int   last_fs_since = 0;
    int   hs_run = 0;
    int   vs_run = 0;
    logic vs_prev = 1'b1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mism++;
            $error("FAIL %s: observed %0h expected %0h (h=%0d v=%0d)", tag, obs, exp, cur_h, cur_v);
        end
        if (mism >= ABORT_AT) begin
            $display("FAIL abort: too many mismatches");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
            $fatal(1, "aborting");
        end
    endtask

    function automatic logic [11:0] ref_rgb(input int x, input int y, input logic [199:0] g,
                                            input logic go);
        int dx;
        int dy;
        if (x >= 640 || y >= 480) return 12'h000;
        if (x >= PF_X0 && x < PF_X0 + 160 && y >= PF_Y0 && y < PF_Y0 + 320) begin
            dx = x - PF_X0;
            dy = y - PF_Y0;
            if (dx % 16 == 15 || dy % 16 == 15) return 12'h222;
            if (g[(dy / 16) * 10 + dx / 16]) return go ? 12'hF00 : 12'h0FF;
            return 12'h222;
        end
        if (x >= PF_X0 - 8 && x < PF_X0 + 168 && y >= PF_Y0 - 8 && y < PF_Y0 + 328) return 12'hFFF;
        return 12'h000;
    endfunction

    function automatic logic [199:0] rand_grid();
        logic [199:0] g;
        for (int i = 0; i < 200; i++) g[i] = 1'($urandom_range(0, 1));
        return g;
    endfunction

    // One clk: predict this edge from the model, then compare on the falling edge.
    task automatic tick();
        int k;
        @(posedge clk);
        exp_fs = 1'b0;
        if (!reset_n) begin
            since    = 0;
            cur_h    = -1;
            cur_v    = -1;
            snap_m   = '0;
            go_m     = 1'b0;
            exp_out  = 14'h3000;
            fs_count = 0;
            hs_run   = 0;
            vs_run   = 0;
        end else begin
            since++;
            if (since >= 2 && since % 2 == 0) begin
                k       = since / 2 - 1;
                cur_h   = k % 800;
                cur_v   = (k / 800) % 525;
                exp_out = {!(cur_h >= 656 && cur_h < 752), !(cur_v >= 490 && cur_v < 492),
                           ref_rgb(cur_h, cur_v, snap_m, go_m)};
                if (cur_h == 0 && cur_v == 480) begin
                    exp_fs = 1'b1;
                    snap_m = grid_state;
                    go_m   = game_over;
                end
            end
        end
        @(negedge clk);
        check("frame_start", frame_start, exp_fs);
        check("pixel_hs_vs_rgb", {vga_hs, vga_vs, vga_r, vga_g, vga_b}, exp_out);

        if (frame_start === 1'b1) begin
            if (fs_count == 0) check("first_frame_start_clk", since, 768002);
            else check("frame_period", since - last_fs_since, 840000);
            fs_count++;
            last_fs_since = since;
        end
        if (vga_hs === 1'b0) hs_run++;
        else begin
            if (hs_run != 0) check("hs_low_width", hs_run, 192);
            hs_run = 0;
        end
        if (vga_vs === 1'b0) begin
            if (vs_prev === 1'b1) check("vs_start_line", cur_v, 490);
            vs_run++;
        end else begin
            if (vs_run != 0) check("vs_low_width", vs_run, 3200);
            vs_run = 0;
        end
        vs_prev = vga_vs;
    endtask

    // Advance until the strobe for pixel (x,y) has just been registered.
    task automatic goto(input int x, input int y);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!(cur_h == x && cur_v == y && since % 2 == 0) && n < GOTO_MAX);
        compared++;
        assert (n < GOTO_MAX) else begin
            mism++;
            $error("FAIL goto_timeout: pixel (%0d,%0d) not reached within %0d clks", x, y, n);
        end
    endtask

    task automatic probe(input string tag, input int x, input int y, input logic [11:0] exp);
        goto(x, y);
        check(tag, {vga_r, vga_g, vga_b}, exp);
    endtask

    initial begin
        reset_n    = 1'b0;
        grid_state = '0;
        game_over  = 1'b0;
        repeat (5) tick();
        check("reset_outputs", {vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start}, 15'h6000);

        // Single cell at (0,0); first frame must still show an empty grid.
        grid_state = 200'd1;
        reset_n    = 1'b1;
        goto(0, 480);

        probe("cell0_top_left", 240, 80, 12'h0FF);
        probe("cell0_gap_col", 255, 80, 12'h222);
        probe("cell1_empty", 256, 80, 12'h222);
        probe("cell0_inner", 254, 94, 12'h0FF);
        probe("left_border", 236, 100, 12'hFFF);

        // Random mid-frame churn must stay invisible until the next snapshot.
        for (int i = 0; i < 20; i++) begin
            goto(0, 110 + i * 18);
            grid_state = rand_grid();
            game_over  = 1'($urandom_range(0, 1));
        end
        goto(799, 479);
        tick();
        grid_state = 200'd1 << 199;
        game_over  = 1'b1;
        goto(0, 480);

        for (int i = 0; i < 10; i++) begin
            goto(0, 10 + i * 18);
            grid_state = rand_grid();
            game_over  = 1'($urandom_range(0, 1));
        end
        goto(0, 200);
        grid_state = {200{1'b1}};
        game_over  = 1'b0;
        probe("corner_cell_red", 384, 384, 12'hF00);
        probe("corner_border", 400, 400, 12'hFFF);
        goto(0, 480);

        probe("full_gap", 255, 80, 12'h222);
        probe("full_cell", 256, 80, 12'h0FF);

        // Mid-frame reset restarts at (0,0) with an empty snapshot.
        goto(0, 300);
        reset_n = 1'b0;
        tick();
        check("midframe_reset_outputs", {vga_hs, vga_vs, vga_r, vga_g, vga_b, frame_start}, 15'h6000);
        reset_n = 1'b1;
        probe("after_reset_empty", 240, 80, 12'h222);
        probe("after_reset_border", 236, 100, 12'hFFF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
        $finish;
    end

endmodule
